ecc_encryption: RTL and testbench

//  Encryption end of the team's ElGamal-style ECC scheme over GF(2^N), projective (X,Y,Z) points.

---
 rtl/ecc_encryption.sv | 180 ++++++++++++++++++
 tb/tb_ecc_encryption.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_encryption.sv
// ecc_encryption: ElGamal-style ECC encryption over GF(2^N) projective points, C1=k*G, C2=M+k*Q.
// Optional ENC_NONCE_LFSR_EN replaces the k port with an internal free-running Galois LFSR nonce.
`default_nettype none

module ecc_encryption #(
  parameter int N   = 3,
  parameter int K_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K_W-1:0] k,
  input  logic [N-1:0]   x_M,
  input  logic [N-1:0]   y_M,
  input  logic [N-1:0]   z_M,
  input  logic [N-1:0]   x_G,
  input  logic [N-1:0]   y_G,
  input  logic [N-1:0]   z_G,
  input  logic [N-1:0]   x_Q,
  input  logic [N-1:0]   y_Q,
  input  logic [N-1:0]   z_Q,
  output logic [N-1:0]   x_C1,
  output logic [N-1:0]   y_C1,
  output logic [N-1:0]   z_C1,
  output logic [N-1:0]   x_C2,
  output logic [N-1:0]   y_C2,
  output logic [N-1:0]   z_C2,
  output logic [K_W-1:0] k_used,
  output logic           busy,
  output logic           Encryption_ready
);

  localparam int IW     = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int POLY_I = (N == 5) ? 5 : (N == 8) ? 27 : 3;
  localparam logic [N-1:0] POLY = POLY_I[N-1:0];

  typedef logic [3*N-1:0] pt_t;
  localparam pt_t PT_INF = {{N{1'b0}}, {{(N-1){1'b0}}, 1'b1}, {N{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, DBL, ADD, FINAL} state_t;

  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] p;
    logic [N-1:0] aa;
    p  = '0;
    aa = a;
    for (int j = 0; j < N; j++) begin
      if (b[j]) p = p ^ aa;
      aa = aa[N-1] ? ((aa << 1) ^ POLY) : (aa << 1);
    end
    return p;
  endfunction

  // Curve y^2 + xy = x^3 + x^2 + b (a = 1), standard projective coordinates.
  function automatic pt_t pt_add(input pt_t p, input pt_t q);
    logic [N-1:0] x1, y1, z1, x2, y2, z2, u, v, vv, vvv, w, t;
    {x1, y1, z1} = p;
    {x2, y2, z2} = q;
    u   = gf_mul(y1, z2) ^ gf_mul(y2, z1);
    v   = gf_mul(x1, z2) ^ gf_mul(x2, z1);
    vv  = gf_mul(v, v);
    vvv = gf_mul(v, vv);
    w   = gf_mul(z1, z2);
    t   = gf_mul(gf_mul(u, u) ^ gf_mul(u, v) ^ vv, w) ^ vvv;
    return {gf_mul(v, t),
            gf_mul(u, gf_mul(vv, gf_mul(x1, z2)) ^ t) ^ gf_mul(vvv, gf_mul(y1, z2)),
            gf_mul(vvv, w)};
  endfunction

  function automatic pt_t pt_dbl(input pt_t p);
    logic [N-1:0] x1, y1, z1, a, b, c, d, e;
    {x1, y1, z1} = p;
    a = gf_mul(x1, x1);
    b = a ^ gf_mul(y1, z1);
    c = gf_mul(x1, z1);
    d = gf_mul(c, c);
    e = gf_mul(b, b) ^ gf_mul(b, c) ^ d;
    return {gf_mul(c, e), gf_mul(b ^ c, e) ^ gf_mul(gf_mul(a, a), c), gf_mul(c, d)};
  endfunction

  state_t         state, state_next;
  pt_t            m_lat, g_lat, q_lat, acc_a, acc_b, c1, c2;
  logic [K_W-1:0] nonce, nonce_in;
  logic [IW-1:0]  idx;
  logic           inf;

`ifdef ENC_NONCE_LFSR_EN
  localparam int TAPS_I = (K_W == 2) ? 3 : (K_W == 3) ? 6 : (K_W == 4) ? 12 :
                          (K_W == 5) ? 20 : (K_W == 6) ? 48 : (K_W == 7) ? 96 : 184;
  localparam logic [K_W-1:0] TAPS = TAPS_I[K_W-1:0];
  logic [K_W-1:0] lfsr;
  logic           k_unused;

  // Maximal-length taps never reach the all-zero state from seed 1.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= {{(K_W-1){1'b0}}, 1'b1};
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end
  assign nonce_in = lfsr;
  assign k_unused = ^k;
`else
  assign nonce_in = k;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = DBL;
      DBL:     state_next = ADD;
      ADD:     state_next = (idx == '0) ? FINAL : DBL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_lat <= '0; g_lat <= '0; q_lat <= '0;
      acc_a <= '0; acc_b <= '0; inf <= 1'b0;
      nonce <= '0; idx <= '0;
      c1 <= '0; c2 <= '0; k_used <= '0;
      busy <= 1'b0; Encryption_ready <= 1'b0;
    end else begin
      Encryption_ready <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_lat  <= {x_M, y_M, z_M};
          g_lat  <= {x_G, y_G, z_G};
          q_lat  <= {x_Q, y_Q, z_Q};
          nonce  <= nonce_in;
          k_used <= nonce_in;
        end
        LOAD: begin
          acc_a <= PT_INF;
          acc_b <= PT_INF;
          inf   <= 1'b1;
          idx   <= IW'(K_W - 1);
          busy  <= 1'b1;
        end
        DBL: if (!inf) begin
          acc_a <= pt_dbl(acc_a);
          acc_b <= pt_dbl(acc_b);
        end
        ADD: begin
          // Both bit values take this one cycle, keeping the schedule constant-time.
          if (nonce[idx]) begin
            if (inf) begin
              acc_a <= g_lat;
              acc_b <= q_lat;
              inf   <= 1'b0;
            end else begin
              acc_a <= pt_add(acc_a, g_lat);
              acc_b <= pt_add(acc_b, q_lat);
            end
          end
          idx <= idx - 1'b1;
        end
        FINAL: begin
          c1   <= inf ? PT_INF : acc_a;
          c2   <= inf ? m_lat : pt_add(m_lat, acc_b);
          busy <= 1'b0;
          Encryption_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {x_C1, y_C1, z_C1} = c1;
  assign {x_C2, y_C2, z_C2} = c2;

endmodule

`default_nettype wire

// File: tb/tb_ecc_encryption.sv
// Scoreboard bench for ecc_encryption: stimulus pushes model results, a monitor checks each ready pulse.
`default_nettype none

module tb_ecc_encryption;
  localparam int N = 3;
  localparam int K_W = 4;
  localparam int FULL_POLY = 11;  // x^3 + x + 1
  localparam int LAT = 2 * K_W + 2;

  typedef struct { int x; int y; int z; } pt_t;
  typedef struct { pt_t c1; pt_t c2; int kk; int rdy; pt_t m; pt_t g; pt_t q; } exp_t;

  logic clk = 0, reset = 1, start = 0;
  logic [K_W-1:0] k = '0;
  logic [N-1:0] x_M = 0, y_M = 0, z_M = 0, x_G = 0, y_G = 0, z_G = 0, x_Q = 0, y_Q = 0, z_Q = 0;
  logic [N-1:0] x_C1, y_C1, z_C1, x_C2, y_C2, z_C2;
  logic [K_W-1:0] k_used;
  logic busy, Encryption_ready;

  int errors = 0, checks = 0, cyc = 0, ready_cnt = 0;
  exp_t sb[$];

  ecc_encryption #(.N(N), .K_W(K_W)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k),
    .x_M(x_M), .y_M(y_M), .z_M(z_M), .x_G(x_G), .y_G(y_G), .z_G(z_G),
    .x_Q(x_Q), .y_Q(y_Q), .z_Q(z_Q),
    .x_C1(x_C1), .y_C1(y_C1), .z_C1(z_C1), .x_C2(x_C2), .y_C2(y_C2), .z_C2(z_C2),
    .k_used(k_used), .busy(busy), .Encryption_ready(Encryption_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gmul(int a, int b);
    int p = 0;
    for (int i = 0; i < N; i++) if (((b >> i) & 1) != 0) p ^= a << i;
    for (int i = 2 * N - 2; i >= N; i--) if (((p >> i) & 1) != 0) p ^= FULL_POLY << (i - N);
    return p & ((1 << N) - 1);
  endfunction

  function automatic pt_t padd(pt_t a, pt_t b);
    pt_t r;
    int u, v, vv, vvv, w, t;
    u = gmul(a.y, b.z) ^ gmul(b.y, a.z);
    v = gmul(a.x, b.z) ^ gmul(b.x, a.z);
    vv = gmul(v, v); vvv = gmul(v, vv); w = gmul(a.z, b.z);
    t = gmul(gmul(u, u) ^ gmul(u, v) ^ vv, w) ^ vvv;
    r.x = gmul(v, t);
    r.y = gmul(u, gmul(vv, gmul(a.x, b.z)) ^ t) ^ gmul(vvv, gmul(a.y, b.z));
    r.z = gmul(vvv, w);
    return r;
  endfunction

  function automatic pt_t pdbl(pt_t p);
    pt_t r;
    int a, b, c, d, e;
    a = gmul(p.x, p.x); b = a ^ gmul(p.y, p.z); c = gmul(p.x, p.z);
    d = gmul(c, c); e = gmul(b, b) ^ gmul(b, c) ^ d;
    r.x = gmul(c, e); r.y = gmul(b ^ c, e) ^ gmul(gmul(a, a), c); r.z = gmul(c, d);
    return r;
  endfunction

  // Scalar multiple by double-and-add; is_inf set when the result is the point at infinity.
  function automatic pt_t smul(int kk, pt_t p, output bit is_inf);
    pt_t acc = '{0, 1, 0};
    is_inf = 1;
    for (int i = K_W - 1; i >= 0; i--) begin
      if (!is_inf) acc = pdbl(acc);
      if (((kk >> i) & 1) != 0) begin
        if (is_inf) begin acc = p; is_inf = 0; end
        else acc = padd(acc, p);
      end
    end
    return acc;
  endfunction

  function automatic exp_t model(int kk, pt_t m, pt_t g, pt_t q);
    exp_t e;
    bit ia, ib;
    pt_t ra, rb;
    ra = smul(kk, g, ia);
    rb = smul(kk, q, ib);
    e.c1 = ia ? '{0, 1, 0} : ra;
    e.c2 = ib ? m : padd(m, rb);
    e.kk = kk; e.m = m; e.g = g; e.q = q; e.rdy = 0;
    return e;
  endfunction

  function automatic int pk(pt_t p);
    return (p.x << (2 * N)) | (p.y << N) | p.z;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_pts(pt_t m, pt_t g, pt_t q);
    x_M = m.x[N-1:0]; y_M = m.y[N-1:0]; z_M = m.z[N-1:0];
    x_G = g.x[N-1:0]; y_G = g.y[N-1:0]; z_G = g.z[N-1:0];
    x_Q = q.x[N-1:0]; y_Q = q.y[N-1:0]; z_Q = q.z[N-1:0];
  endtask

  function automatic pt_t rpt();
    pt_t p;
    p.x = $urandom_range(0, 7); p.y = $urandom_range(0, 7); p.z = $urandom_range(0, 7);
    return p;
  endfunction

  // Called at a negedge with the DUT idle: start is sampled on the next posedge.
  task automatic issue(int kk, pt_t m, pt_t g, pt_t q);
    exp_t e;
    set_pts(m, g, q);
    k = kk[K_W-1:0];
    start = 1;
    e = model(kk, m, g, q);
    e.rdy = cyc + 1 + LAT;
    sb.push_back(e);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (Encryption_ready) begin
      ready_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_ready: ready=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
`ifdef ENC_NONCE_LFSR_EN
        check("k_used_nonzero", int'(k_used != 0), 1);
        e = model(int'(k_used), e.m, e.g, e.q);
`else
        check("k_used", int'(k_used), e.kk);
        check("latency", cyc, e.rdy);
`endif
        check("C1", int'({x_C1, y_C1, z_C1}), pk(e.c1));
        check("C2", int'({x_C2, y_C2, z_C2}), pk(e.c2));
      end
    end
  end

  pt_t G = '{2, 3, 1}, Q = '{5, 6, 1}, M = '{4, 1, 1};

  initial begin
    int bcnt, t, n, c0, last;
    exp_t e;

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({x_C1, y_C1, z_C1, x_C2, y_C2, z_C2, k_used}), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(Encryption_ready), 0);
    reset = 0;
    @(negedge clk);

    // k = 0: infinity for C1, M for C2, busy for exactly 9 cycles.
    issue(0, M, G, Q);
    bcnt = 0;
    repeat (14) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("busy_cycles", bcnt, 9);
    wait_done();

    issue(1, M, G, Q); wait_done();
    issue(2, M, G, Q); wait_done();

    // Inputs changed mid-operation must not disturb the latched operands.
    issue(11, M, G, Q);
    repeat (3) @(negedge clk);
    k = 4'd6; set_pts(rpt(), rpt(), rpt());
    wait_done();

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue($urandom_range(0, 15), rpt(), rpt(), rpt());
      wait_done();
    end

    // start held high: a new operation is accepted in each ready cycle.
    set_pts(M, G, Q);
    k = 4'd3;
    e = model(3, M, G, Q);
    e.rdy = cyc + 1 + LAT;
    sb.push_back(e);
    start = 1;
    n = 0; t = 0; last = 0;
    while (n < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (Encryption_ready) begin
        if (n > 0) check("b2b_interval", cyc - last, LAT + 1);
        last = cyc;
        n++;
        if (n < 4) begin e.rdy = cyc + 1 + LAT; sb.push_back(e); end
        else start = 0;
      end
    end
    start = 0;
    check("b2b_results", n, 4);
    wait_done();

    // start pulsed while busy is ignored.
    c0 = ready_cnt;
    issue(5, M, G, Q);
    repeat (4) @(negedge clk);
    k = 4'd9; start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    repeat (15) @(negedge clk);
    check("ignored_start", ready_cnt - c0, 1);

    // Reset in the ADD cycle of bit 2 aborts the operation.
    issue(13, rpt(), G, Q);
    repeat (4) @(negedge clk);
    reset = 1;
    sb.delete();
    @(negedge clk);
    check("abort_outputs", int'({x_C1, y_C1, z_C1, x_C2, y_C2, z_C2, k_used}), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(Encryption_ready), 0);
    reset = 0;
    c0 = ready_cnt;
    repeat (15) @(negedge clk);
    check("abort_no_ready", ready_cnt - c0, 0);
    issue(7, M, G, Q);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
